uart_rx_core: RTL and testbench

Parametrised, self-contained UART receiver that merges the receive datapath and its control FSM into one block. Supports 5–9 data bits, none/even/odd parity, 1 or 2 stop bits and configurable oversampling, with 3-sample majority voting. Delivers each received word with a valid/ack handshake and per-frame error flags: parity, framing, break and overrun. Sits between the pad-side serial input and the host register interface; the baud tick comes from an external baud generator.

---
 rtl/uart_rx_core_if.sv | 23 ++
 rtl/uart_rx_core.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// Host-side bundle of the UART receiver: received word, per-frame flags and
// the consume acknowledge. The receiver uses master, the register block slave.
interface uart_rx_core_if #(
  parameter int DATA_SIZE = 8
);
  logic                 rx_ack;
  logic [DATA_SIZE-1:0] Rx_out;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 overrun;

  modport master (
    input  rx_ack,
    output Rx_out, rx_valid, parity_err, frame_err, break_det, overrun
  );

  modport slave (
    output rx_ack,
    input  Rx_out, rx_valid, parity_err, frame_err, break_det, overrun
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: 2-flop synchronizer, 3-sample majority vote,
// frame FSM and a valid/ack output register with parity/frame/break/overrun flags.
module uart_rx_core #(
  parameter int DATA_SIZE   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int CNTR_WIDTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sample_tick,
  input  logic           Rx,
  uart_rx_core_if.master host,
  output logic           busy
);

  localparam int M = OVERSAMPLE / 2;
  localparam logic [CNTR_WIDTH-1:0] CNT_LAST = CNTR_WIDTH'(OVERSAMPLE - 1);
  localparam logic [CNTR_WIDTH-1:0] VOTE_A   = CNTR_WIDTH'(M - 1);
  localparam logic [CNTR_WIDTH-1:0] VOTE_B   = CNTR_WIDTH'(M);
  localparam logic [CNTR_WIDTH-1:0] VOTE_C   = CNTR_WIDTH'(M + 1);
  localparam logic [3:0]            LAST_BIT = 4'(DATA_SIZE - 1);
  localparam logic                  ODD_PAR  = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } state_t;

  state_t state, state_nxt;

  logic                  rx_sync_p0;
  logic                  rx_s;
  logic [CNTR_WIDTH-1:0] cnt;
  logic [3:0]            bit_idx;
  logic                  stop_idx;
  logic                  samp_a;
  logic                  samp_b;
  logic [DATA_SIZE-1:0]  shift;
  logic                  p_err;
  logic                  f_err;
  logic                  brk_acc;

  logic                  wrap;
  logic                  vote_tick;
  logic                  vote;
  logic                  last_stop;
  logic                  data_par;
  logic                  f_final;
  logic                  brk_final;
  logic                  frame_start;
  logic                  frame_done;

  logic [DATA_SIZE-1:0]  rx_out_q;
  logic                  valid_q;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  brk_q;
  logic                  ovr_q;

  // 2-3 majority of the samples taken at cnt = M-1, M and the live one at M+1
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchronizer stage: rx_sync_p0 -> rx_s, idle-high after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_sync_p0 <= Rx;
      rx_s       <= rx_sync_p0;
    end
  end

  assign wrap      = sample_tick && (cnt == CNT_LAST);
  assign vote_tick = sample_tick && (cnt == VOTE_C);
  assign vote      = majority3(samp_a, samp_b, rx_s);
  assign last_stop = (STOP_BITS == 2) ? stop_idx : 1'b1;
  assign data_par  = ^shift;
  // Final stop vote folds straight into the reported flags, no extra cycle
  assign f_final   = f_err | ~vote;
  assign brk_final = brk_acc & ~vote;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick && !rx_s) begin
          state_nxt   = START;
          frame_start = 1'b1;
        end
      end
      START: begin
        if (vote_tick && vote) state_nxt = IDLE;
        else if (wrap)         state_nxt = DATA;
      end
      DATA: begin
        if (wrap && (bit_idx == LAST_BIT)) begin
          if (PARITY_MODE != 0) state_nxt = PARITY;
          else                  state_nxt = STOP;
        end
      end
      PARITY: begin
        if (wrap) state_nxt = STOP;
      end
      STOP: begin
        if (vote_tick && last_stop) begin
          frame_done = 1'b1;
          if (brk_final) state_nxt = BRK_WAIT;
          else           state_nxt = IDLE;
        end
      end
      BRK_WAIT: begin
        if (sample_tick && rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing and per-frame error accumulation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      p_err    <= 1'b0;
      f_err    <= 1'b0;
      brk_acc  <= 1'b0;
    end else begin
      if (state == IDLE || state == BRK_WAIT) cnt <= '0;
      else if (sample_tick)                   cnt <= wrap ? '0 : cnt + CNTR_WIDTH'(1);

      if (frame_start)                  bit_idx <= '0;
      else if (state == DATA && wrap)   bit_idx <= bit_idx + 4'd1;

      if (frame_start)                  stop_idx <= 1'b0;
      else if (state == STOP && wrap)   stop_idx <= 1'b1;

      if (frame_start) begin
        p_err   <= 1'b0;
        f_err   <= 1'b0;
        brk_acc <= 1'b1;
      end else if (vote_tick) begin
        case (state)
          DATA:    brk_acc <= brk_acc & ~vote;
          PARITY: begin
            p_err   <= vote ^ data_par ^ ODD_PAR;
            brk_acc <= brk_acc & ~vote;
          end
          STOP: begin
            f_err   <= f_final;
            brk_acc <= brk_final;
          end
          default: ;
        endcase
      end
    end
  end

  // Vote samples and shift register carry no reset; every frame overwrites them
  always_ff @(posedge clk) begin
    if (sample_tick && cnt == VOTE_A) samp_a <= rx_s;
    if (sample_tick && cnt == VOTE_B) samp_b <= rx_s;
    if (vote_tick && state == DATA) begin
      for (int i = 0; i < DATA_SIZE; i++) begin
        if (bit_idx == 4'(i)) shift[i] <= vote;
      end
    end
  end

  // Output stage: a completing frame wins over ack; ack alone clears the flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_out_q <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else if (frame_done) begin
      if (!valid_q || host.rx_ack) begin
        rx_out_q <= shift;
        perr_q   <= p_err;
        ferr_q   <= f_final;
        brk_q    <= brk_final;
        valid_q  <= 1'b1;
        ovr_q    <= 1'b0;
      end else begin
        ovr_q    <= 1'b1;
      end
    end else if (valid_q && host.rx_ack) begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign host.Rx_out     = rx_out_q;
  assign host.rx_valid   = valid_q;
  assign host.parity_err = perr_q;
  assign host.frame_err  = ferr_q;
  assign host.break_det  = brk_q;
  assign host.overrun    = ovr_q;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: 8E1, 8O1 and 8N2 instances driven with directed and
// random frames, each result compared against a frame-level model.
module tb_uart_rx_core;
  localparam int OS      = 16;
  localparam int BIT_CLK = OS * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  tick_div = '0;
  logic        tick;
  logic        rx_line [3];
  logic        ack [3];
  logic        busy0, busy1, busy2;
  logic [13:0] st [3];
  int          cyc = 0;
  int          start_cyc;
  int          delta;
  int          checks = 0;
  int          failures = 0;
  int          par_mode [3] = '{1, 2, 0};
  int          stop_n [3]   = '{1, 1, 2};

  always #5 clk = ~clk;
  always @(posedge clk) begin
    tick_div <= tick_div + 2'd1;
    cyc      <= cyc + 1;
  end
  assign tick = (tick_div == 2'd3);

  uart_rx_core_if #(.DATA_SIZE(8)) if_e1 ();
  uart_rx_core_if #(.DATA_SIZE(8)) if_o1 ();
  uart_rx_core_if #(.DATA_SIZE(8)) if_n2 ();

  uart_rx_core #(.DATA_SIZE(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(OS), .CNTR_WIDTH(4)) u_e1 (
    .clk(clk), .rst(rst), .sample_tick(tick), .Rx(rx_line[0]), .host(if_e1), .busy(busy0));
  uart_rx_core #(.DATA_SIZE(8), .PARITY_MODE(2), .STOP_BITS(1), .OVERSAMPLE(OS), .CNTR_WIDTH(4)) u_o1 (
    .clk(clk), .rst(rst), .sample_tick(tick), .Rx(rx_line[1]), .host(if_o1), .busy(busy1));
  uart_rx_core #(.DATA_SIZE(8), .PARITY_MODE(0), .STOP_BITS(2), .OVERSAMPLE(OS), .CNTR_WIDTH(4)) u_n2 (
    .clk(clk), .rst(rst), .sample_tick(tick), .Rx(rx_line[2]), .host(if_n2), .busy(busy2));

  assign if_e1.rx_ack = ack[0];
  assign if_o1.rx_ack = ack[1];
  assign if_n2.rx_ack = ack[2];

  // Status word: {busy, overrun, break, frame_err, parity_err, valid, data}
  assign st[0] = {busy0, if_e1.overrun, if_e1.break_det, if_e1.frame_err, if_e1.parity_err, if_e1.rx_valid, if_e1.Rx_out};
  assign st[1] = {busy1, if_o1.overrun, if_o1.break_det, if_o1.frame_err, if_o1.parity_err, if_o1.rx_valid, if_o1.Rx_out};
  assign st[2] = {busy2, if_n2.overrun, if_n2.break_det, if_n2.frame_err, if_n2.parity_err, if_n2.rx_valid, if_n2.Rx_out};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align();
    @(posedge clk iff tick);
    #1;
    start_cyc = cyc;
  endtask

  // Parity bit a correct transmitter would send for this instance
  function automatic logic good_parity(input int d, input logic [7:0] data);
    logic odd_ones;
    odd_ones = ($countones(data) % 2) == 1;
    return (par_mode[d] == 2) ? !odd_ones : odd_ones;
  endfunction

  function automatic logic [13:0] model(input int d, input logic [7:0] data,
                                        input logic pbit, input logic s1, input logic s2);
    logic perr, ferr, brk;
    perr = (par_mode[d] != 0) && (pbit != good_parity(d, data));
    ferr = !s1 || (stop_n[d] == 2 && !s2);
    brk  = (data == 8'h00) && (par_mode[d] == 0 || !pbit) && !s1 && (stop_n[d] == 1 || !s2);
    return {1'b0, 1'b0, brk, ferr, perr, 1'b1, data};
  endfunction

  task automatic send_frame(input int d, input logic [7:0] data, input logic pbit,
                            input logic s1, input logic s2, input logic noise);
    logic bits [12];
    int   nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
    nb = 9;
    if (par_mode[d] != 0) begin bits[nb] = pbit; nb++; end
    bits[nb] = s1; nb++;
    if (stop_n[d] == 2) begin bits[nb] = s2; nb++; end
    align();
    for (int i = 0; i < nb; i++) begin
      rx_line[d] = bits[i];
      if (noise && i >= 1 && i <= 8) begin
        wait_clk(36);
        rx_line[d] = ~bits[i];
        wait_clk(4);
        rx_line[d] = bits[i];
        wait_clk(BIT_CLK - 40);
      end else begin
        wait_clk(BIT_CLK);
      end
    end
    rx_line[d] = 1'b1;
  endtask

  task automatic run_check(input int d, input logic [7:0] data, input logic pbit,
                           input logic s1, input logic s2, input logic noise, input string tag);
    send_frame(d, data, pbit, s1, s2, noise);
    wait_clk(80);
    check_eq(tag, st[d], model(d, data, pbit, s1, s2));
  endtask

  task automatic ack_check(input int d, input logic [7:0] data, input string tag);
    ack[d] = 1'b1;
    wait_clk(1);
    ack[d] = 1'b0;
    check_eq(tag, st[d], {6'b0, data});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    logic       pb, s1, s2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin rx_line[i] = 1'b1; ack[i] = 1'b0; end
    wait_clk(5);
    for (int i = 0; i < 3; i++) check_eq($sformatf("reset_state_%0d", i), st[i], 14'h0);
    rst = 1'b1;
    wait_clk(20);

    // 8E1 basic word, hold until ack, drop one cycle after ack
    run_check(0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, "e1_a5");
    wait_clk(100);
    check_eq("e1_hold_valid", st[0][8], 1'b1);
    ack[0] = 1'b1;
    #1;
    check_eq("e1_valid_before_edge", st[0][8], 1'b1);
    wait_clk(1);
    ack[0] = 1'b0;
    check_eq("e1_after_ack", st[0], {6'b0, 8'hA5});

    // 4-tick low glitch is a false start
    align();
    rx_line[0] = 1'b0;
    wait_clk(16);
    rx_line[0] = 1'b1;
    check_eq("glitch_busy", busy0, 1'b1);
    wait_clk(40);
    check_eq("glitch_idle", busy0, 1'b0);
    check_eq("glitch_no_valid", st[0][8], 1'b0);

    // 8O1 wrong then correct parity
    run_check(1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, "o1_bad_par");
    ack_check(1, 8'h3C, "o1_ack1");
    run_check(1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, "o1_good_par");
    ack_check(1, 8'h3C, "o1_ack2");

    // 8N2 second stop low, then a line break
    run_check(2, 8'h6D, 1'b0, 1'b1, 1'b0, 1'b0, "n2_stop2_low");
    ack_check(2, 8'h6D, "n2_ack1");
    align();
    rx_line[2] = 1'b0;
    wait_clk(22 * BIT_CLK);
    check_eq("n2_break", st[2], model(2, 8'h00, 1'b0, 1'b0, 1'b0) | 14'h2000);
    rx_line[2] = 1'b1;
    wait_clk(12);
    check_eq("n2_break_release", busy2, 1'b0);
    ack_check(2, 8'h00, "n2_ack2");

    // Overrun: two frames without ack; first frame also measures latency
    fork
      send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
      begin : watch_valid
        int n;
        n = 0;
        while (st[0][8] !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        delta = cyc - start_cyc;
      end
    join
    check_eq("calib_valid", st[0][8], 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_clk(80);
    check_eq("overrun_set", st[0], model(0, 8'h11, 1'b0, 1'b1, 1'b1) | 14'h1000);
    ack_check(0, 8'h11, "overrun_ack");
    run_check(0, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, "after_overrun");

    // Ack lands in the same cycle the next frame completes
    start_cyc = -1;
    fork
      send_frame(0, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0);
      begin : coincide_ack
        while (start_cyc < 0) @(negedge clk);
        while (cyc < start_cyc + delta - 1) @(negedge clk);
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
      end
    join
    wait_clk(80);
    check_eq("ack_coincident", st[0], model(0, 8'h44, 1'b1, 1'b1, 1'b1));
    ack_check(0, 8'h44, "coincident_ack");

    // One-tick noise at the centre sample of every data bit
    run_check(0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, "noise_5a");

    // Reset in the middle of DATA with a word still pending
    align();
    rx_line[0] = 1'b0;
    wait_clk(BIT_CLK);
    rx_line[0] = 1'b1;
    wait_clk(3 * BIT_CLK);
    rst = 1'b0;
    #1;
    check_eq("mid_reset", st[0], 14'h0);
    wait_clk(3);
    rst = 1'b1;
    wait_clk(BIT_CLK);
    run_check(0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, "post_reset_81");
    ack_check(0, 8'h81, "post_reset_ack");

    // Random frames on every instance
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 6; k++) begin
        rd = 8'($urandom_range(0, 255));
        pb = good_parity(d, rd) ^ ($urandom_range(0, 3) == 0);
        s1 = ($urandom_range(0, 4) != 0);
        s2 = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 7) == 0) begin
          rd = 8'h00; pb = 1'b0; s1 = 1'b0; s2 = 1'b0;
        end
        run_check(d, rd, pb, s1, s2, 1'b0, $sformatf("rand_d%0d_%0d", d, k));
        ack_check(d, rd, $sformatf("rand_ack_d%0d_%0d", d, k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
